// File: rtl/dcf77_sync_clock.sv
// DCF77-qualified free-running BCD date/time clock with leap-year and leap-second handling.
// Frames are checked against local time; a lock/holdover state machine decides whether to load them.
module dcf77_sync_clock #(
  parameter int TICKS_PER_SEC = 100,
  parameter int SYNC_PHASE    = 7,
  parameter int CONFIRM       = 2,
  parameter int REJECT_MAX    = 3,
  parameter int HOLDOVER_SEC  = 3600,
  parameter bit Y00_LEAP      = 1'b1
) (
  input  logic       reset,
  input  logic       clk,
  input  logic       clk_en,
  input  logic       dcf77_sync,
  input  logic       leap_announce,
  input  logic [7:0] dcf77_year,
  input  logic [7:0] dcf77_month,
  input  logic [7:0] dcf77_day,
  input  logic [2:0] dcf77_day_of_week,
  input  logic [7:0] dcf77_hour,
  input  logic [7:0] dcf77_minute,
  output logic [7:0] clock_year,
  output logic [7:0] clock_month,
  output logic [7:0] clock_day,
  output logic [2:0] clock_day_of_week,
  output logic [7:0] clock_hour,
  output logic [7:0] clock_minute,
  output logic [7:0] clock_second,
  output logic       locked,
  output logic       holdover,
  output logic       reject,
  output logic       sec_pulse
);
  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam int HW = $clog2(HOLDOVER_SEC + 1);
  localparam logic [CW-1:0] TOP    = CW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] PHASE  = CW'(SYNC_PHASE);
  localparam logic [HW-1:0] HOLD_N = HW'(HOLDOVER_SEC);
  localparam logic [3:0]    CONF_N = 4'(CONFIRM);
  localparam logic [3:0]    REJ_N  = 4'(REJECT_MAX);

  localparam logic [1:0] S_FREE     = 2'd0;
  localparam logic [1:0] S_ACQUIRE  = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;
  localparam logic [1:0] S_HOLDOVER = 2'd3;

  logic [CW-1:0] cnt;
  logic [HW-1:0] hold_tmr;
  logic [7:0]    year, month, day, hour, minute, second;
  logic [2:0]    dow;
  logic [1:0]    state, st_n;
  logic [3:0]    confirm, conf_n, rej_cnt, rcnt_n;
  logic          leap_pending;

  logic [7:0] n_year, n_month, n_day, n_hour, n_min, n_sec, day_max;
  logic [2:0] n_dow;
  logic       n_lp, leap_year, consistent, load, rej;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : {v[7:4], v[3:0] + 4'h1};
  endfunction

  // tens*10 mod 4 == tens*2 mod 4, so only tens[0] and ones[1:0] matter
  always_comb begin
    leap_year = (2'({year[4], 1'b0} + year[1:0]) == 2'b00);
    if (year == 8'h00) leap_year = Y00_LEAP;
    case (month)
      8'h02:                      day_max = leap_year ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: day_max = 8'h30;
      default:                    day_max = 8'h31;
    endcase
  end

  always_comb begin
    n_sec = second; n_min = minute; n_hour = hour; n_day = day;
    n_month = month; n_year = year; n_dow = dow; n_lp = leap_pending;
    if (second == 8'h59 && leap_pending && minute == 8'h59) n_sec = 8'h60;
    else if (second >= 8'h59) begin
      n_sec = 8'h00;
      if (second == 8'h60) n_lp = 1'b0;
      if (minute >= 8'h59) begin
        n_min = 8'h00;
        if (hour >= 8'h23) begin
          n_hour = 8'h00;
          n_dow  = (dow >= 3'd7) ? 3'd1 : dow + 3'd1;
          if (day >= day_max) begin
            n_day = 8'h01;
            if (month >= 8'h12) begin
              n_month = 8'h01;
              n_year  = (year >= 8'h99) ? 8'h00 : bcd_inc(year);
            end else n_month = bcd_inc(month);
          end else n_day = bcd_inc(day);
        end else n_hour = bcd_inc(hour);
      end else n_min = bcd_inc(minute);
    end else n_sec = bcd_inc(second);
  end

  assign consistent = (second == 8'h00) && (dcf77_minute == minute) && (dcf77_hour == hour) &&
                      (dcf77_day == day) && (dcf77_month == month) && (dcf77_year == year) &&
                      (dcf77_day_of_week == dow);

  always_comb begin
    load = 1'b0; rej = 1'b0; st_n = state; conf_n = confirm; rcnt_n = rej_cnt;
    if (clk_en && dcf77_sync) begin
      case (state)
        S_FREE: begin
          load = 1'b1; conf_n = 4'd1;
          st_n = (CONF_N == 4'd1) ? S_LOCKED : S_ACQUIRE;
        end
        S_LOCKED: begin
          if (consistent) begin
            load = 1'b1; rcnt_n = 4'd0;
          end else begin
            rej = 1'b1; rcnt_n = rej_cnt + 4'd1;
            if (rcnt_n >= REJ_N) begin
              load = 1'b1; conf_n = 4'd1; rcnt_n = 4'd0; st_n = S_ACQUIRE;
            end
          end
        end
        default: begin
          load = 1'b1;
          if (consistent) begin
            conf_n = (confirm >= CONF_N) ? CONF_N : confirm + 4'd1;
            if (conf_n == CONF_N) begin
              st_n = S_LOCKED; rcnt_n = 4'd0;
            end
          end else begin
            rej = 1'b1; conf_n = 4'd1; st_n = S_ACQUIRE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0; hold_tmr <= '0; state <= S_FREE; confirm <= 4'd0; rej_cnt <= 4'd0;
      leap_pending <= 1'b0; reject <= 1'b0; sec_pulse <= 1'b0;
      year <= 8'h00; month <= 8'h01; day <= 8'h01; dow <= 3'd1;
      hour <= 8'h00; minute <= 8'h00; second <= 8'h00;
    end else begin
      reject    <= 1'b0;
      sec_pulse <= 1'b0;
      if (clk_en) begin
        state   <= st_n;
        confirm <= conf_n;
        rej_cnt <= rcnt_n;
        reject  <= rej;
        if (load) begin
          year <= dcf77_year; month <= dcf77_month; day <= dcf77_day; dow <= dcf77_day_of_week;
          hour <= dcf77_hour; minute <= dcf77_minute; second <= 8'h00;
          cnt <= PHASE; hold_tmr <= '0;
          leap_pending <= leap_pending | leap_announce;
        end else if (cnt == TOP) begin
          cnt <= '0;
          year <= n_year; month <= n_month; day <= n_day; dow <= n_dow;
          hour <= n_hour; minute <= n_min; second <= n_sec;
          leap_pending <= n_lp;
          sec_pulse <= 1'b1;
          if (hold_tmr != HOLD_N) hold_tmr <= hold_tmr + HW'(1);
          if (st_n == S_LOCKED && hold_tmr >= HOLD_N - HW'(1)) state <= S_HOLDOVER;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign clock_year = year;   assign clock_month = month;   assign clock_day = day;
  assign clock_hour = hour;   assign clock_minute = minute; assign clock_second = second;
  assign clock_day_of_week = dow;
  assign locked   = (state == S_LOCKED);
  assign holdover = (state == S_HOLDOVER);
endmodule

// File: tb/tb_dcf77_sync_clock.sv
// Bench for dcf77_sync_clock: an integer-time reference model checked every cycle,
// plus directed frames with hand-computed date/time expectations at boundaries.
module tb_dcf77_sync_clock;
  localparam int TPS = 10, PH = 3, CONF = 2, RMAX = 3, HSEC = 10;
  localparam bit Y00L = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b0, dcf77_sync = 1'b0, leap_announce = 1'b0;
  logic [7:0] dcf77_year = 8'h0, dcf77_month = 8'h1, dcf77_day = 8'h1;
  logic [7:0] dcf77_hour = 8'h0, dcf77_minute = 8'h0;
  logic [2:0] dcf77_day_of_week = 3'd1;
  logic [7:0] clock_year, clock_month, clock_day, clock_hour, clock_minute, clock_second;
  logic [2:0] clock_day_of_week;
  logic locked, holdover, reject, sec_pulse;

  int n_chk = 0, n_fail = 0, npulse = 0;

  dcf77_sync_clock #(.TICKS_PER_SEC(TPS), .SYNC_PHASE(PH), .CONFIRM(CONF), .REJECT_MAX(RMAX),
                     .HOLDOVER_SEC(HSEC), .Y00_LEAP(Y00L)) dut (
    .reset(reset), .clk(clk), .clk_en(clk_en), .dcf77_sync(dcf77_sync), .leap_announce(leap_announce),
    .dcf77_year(dcf77_year), .dcf77_month(dcf77_month), .dcf77_day(dcf77_day),
    .dcf77_day_of_week(dcf77_day_of_week), .dcf77_hour(dcf77_hour), .dcf77_minute(dcf77_minute),
    .clock_year(clock_year), .clock_month(clock_month), .clock_day(clock_day),
    .clock_day_of_week(clock_day_of_week), .clock_hour(clock_hour), .clock_minute(clock_minute),
    .clock_second(clock_second), .locked(locked), .holdover(holdover), .reject(reject),
    .sec_pulse(sec_pulse));

  always #5 clk = ~clk;

  function automatic logic [7:0] i2b(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // ---------------- reference model (binary integers, one clk_en at a time) ----------------
  typedef enum {M_FREE, M_ACQ, M_LOCK, M_HOLD} mstate_t;
  mstate_t ms;
  int yr, mo, dy, dw, hr, mi, se, cnt, conf, rc, hold;
  bit lp, m_rej, m_secp;
  int f_yr = 0, f_mo = 1, f_dy = 1, f_dw = 1, f_hr = 0, f_mi = 0;

  function automatic int dim(input int y, input int m);
    if (m == 2) return ((y % 4 == 0) && (y != 0 || Y00L)) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic m_next_second();
    if (se == 59 && lp && mi == 59) se = 60;
    else if (se < 59) se++;
    else begin
      if (se == 60) lp = 0;
      se = 0; mi++;
      if (mi == 60) begin
        mi = 0; hr++;
        if (hr == 24) begin
          hr = 0; dw = dw % 7 + 1; dy++;
          if (dy > dim(yr, mo)) begin
            dy = 1; mo++;
            if (mo == 13) begin mo = 1; yr = (yr + 1) % 100; end
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      yr = 0; mo = 1; dy = 1; dw = 1; hr = 0; mi = 0; se = 0;
      cnt = 0; ms = M_FREE; conf = 0; rc = 0; hold = 0; lp = 0; m_rej = 0; m_secp = 0;
    end else begin
      bit ld, cons;
      m_rej = 0; m_secp = 0; ld = 0;
      if (clk_en) begin
        if (dcf77_sync) begin
          cons = (se == 0) && f_mi == mi && f_hr == hr && f_dy == dy && f_mo == mo &&
                 f_yr == yr && f_dw == dw;
          if (ms == M_FREE) begin
            ld = 1; conf = 1; ms = (CONF == 1) ? M_LOCK : M_ACQ;
          end else if (ms == M_LOCK) begin
            if (cons) begin ld = 1; rc = 0; end
            else begin
              m_rej = 1; rc++;
              if (rc >= RMAX) begin ld = 1; conf = 1; rc = 0; ms = M_ACQ; end
            end
          end else begin
            ld = 1;
            if (cons) begin
              conf = (conf + 1 > CONF) ? CONF : conf + 1;
              if (conf == CONF) begin ms = M_LOCK; rc = 0; end
            end else begin m_rej = 1; conf = 1; ms = M_ACQ; end
          end
        end
        if (ld) begin
          yr = f_yr; mo = f_mo; dy = f_dy; dw = f_dw; hr = f_hr; mi = f_mi; se = 0;
          cnt = PH; hold = 0; lp = lp | leap_announce;
        end else if (cnt == TPS - 1) begin
          cnt = 0; m_next_second(); m_secp = 1;
          if (hold < HSEC) hold++;
          if (ms == M_LOCK && hold >= HSEC) ms = M_HOLD;
        end else cnt++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [54:0] dut_vec, exp_vec;
  assign dut_vec = {clock_year, clock_month, clock_day, clock_day_of_week, clock_hour, clock_minute,
                    clock_second, locked, holdover, reject, sec_pulse};

  always @(negedge clk) begin
    exp_vec = {i2b(yr), i2b(mo), i2b(dy), 3'(dw), i2b(hr), i2b(mi), i2b(se),
               ms == M_LOCK, ms == M_HOLD, m_rej, m_secp};
    n_chk++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t: got %h expected %h", $time, dut_vec, exp_vec);
      if (n_fail > 200) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
    if (sec_pulse) npulse++;
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk); clk_en = 0; dcf77_sync = 0; leap_announce = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); clk_en = 1; dcf77_sync = 0; leap_announce = 0;
      if (i % 8 == 7) begin @(negedge clk); clk_en = 0; end
    end
  endtask

  task automatic set_frame(input int y, input int m, input int d, input int w, input int h, input int mn);
    f_yr = y; f_mo = m; f_dy = d; f_dw = w; f_hr = h; f_mi = mn;
    dcf77_year = i2b(y); dcf77_month = i2b(m); dcf77_day = i2b(d);
    dcf77_day_of_week = 3'(w); dcf77_hour = i2b(h); dcf77_minute = i2b(mn);
  endtask

  task automatic frame(input int y, input int m, input int d, input int w, input int h, input int mn,
                       input bit la);
    @(negedge clk);
    set_frame(y, m, d, w, h, mn);
    clk_en = 1; dcf77_sync = 1; leap_announce = la;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    chk("reset_time", {clock_hour, clock_minute, clock_second}, 24'h000000);
    chk("reset_date", {clock_year, clock_month, clock_day, 5'd0, clock_day_of_week}, 32'h00010101);

    // free run: one minute of ticks
    npulse = 0;
    ticks(600); idle();
    chk("free_minute", {clock_hour, clock_minute, clock_second}, 24'h000100);
    chk("free_pulses", 64'(npulse), 64'd60);
    chk("free_unlocked", {locked, holdover}, 2'b00);

    // sync without clk_en is ignored
    @(negedge clk); set_frame(24, 2, 28, 3, 23, 59); clk_en = 0; dcf77_sync = 1;
    idle();
    chk("sync_no_en", clock_hour, 8'h00);

    // acquisition across a leap-year February
    frame(24, 2, 28, 3, 23, 59, 0); idle();
    chk("acq_load", {clock_day, clock_hour, clock_minute, 7'd0, locked}, 32'h28235900);
    ticks(599); frame(24, 2, 29, 4, 0, 0, 0); idle();
    chk("acq_locked", {clock_month, clock_day, 5'd0, clock_day_of_week, 7'd0, locked}, 32'h02290401);
    ticks(96); idle();
    chk("hold_before", holdover, 1'b0);
    ticks(1); idle();
    chk("hold_after", {locked, holdover}, 2'b01);
    frame(24, 2, 29, 4, 23, 59, 0); idle();
    chk("hold_reload", {clock_hour, 7'd0, reject}, 16'h2301);
    ticks(599); frame(24, 3, 1, 5, 0, 0, 0); idle();
    chk("leap_feb_end", {clock_month, clock_day, 5'd0, clock_day_of_week, 7'd0, locked}, 32'h03010501);

    // non-leap year
    ticks(100);
    frame(23, 2, 28, 2, 23, 59, 0);
    ticks(600); idle();
    chk("nonleap_feb", {clock_year, clock_month, clock_day, 5'd0, clock_day_of_week}, 32'h23030103);

    // bad-frame rejection while locked
    frame(23, 5, 10, 3, 11, 59, 0);
    ticks(599); frame(23, 5, 10, 3, 12, 0, 0);
    ticks(20); frame(23, 5, 10, 3, 17, 45, 0); idle();
    chk("rej_one", {clock_hour, clock_minute, 6'd0, locked, reject}, 24'h120003);
    ticks(10); frame(23, 5, 10, 3, 17, 45, 0);
    ticks(10); frame(23, 5, 10, 3, 17, 45, 0); idle();
    chk("rej_three", {clock_hour, clock_minute, 6'd0, locked, reject}, 24'h174501);

    // leap second
    frame(23, 5, 11, 4, 0, 57, 0);
    ticks(599); frame(23, 5, 11, 4, 0, 58, 1);
    ticks(1187); idle();
    chk("leap_59", {clock_hour, clock_minute, clock_second}, 24'h005959);
    ticks(10); idle();
    chk("leap_60", {clock_hour, clock_minute, clock_second}, 24'h005960);
    ticks(10); idle();
    chk("leap_after", {clock_hour, clock_minute, clock_second}, 24'h010000);
    frame(23, 5, 11, 4, 1, 58, 0);
    ticks(1197); idle();
    chk("noleap_hour", {clock_hour, clock_minute, clock_second}, 24'h020000);

    // century rollover
    frame(99, 12, 31, 7, 23, 59, 0);
    ticks(587); idle();
    chk("roll_before", {clock_year, clock_hour, clock_minute, clock_second}, 32'h99235959);
    ticks(10); idle();
    chk("roll_date", {clock_year, clock_month, clock_day, 5'd0, clock_day_of_week}, 32'h00010101);
    chk("roll_time", {clock_hour, clock_minute, clock_second}, 24'h000000);

    // 30-day month and year-00 February
    frame(24, 4, 30, 2, 23, 59, 0);
    ticks(600); idle();
    chk("apr_end", {clock_month, clock_day}, 16'h0501);
    frame(0, 2, 28, 1, 23, 59, 0);
    ticks(600); idle();
    chk("y00_leap", {clock_year, clock_month, clock_day}, 24'h000229);

    // asynchronous reset between edges
    ticks(5);
    @(posedge clk); #2; reset = 1; #1;
    chk("async_reset", dut_vec, {8'h00, 8'h01, 8'h01, 3'd1, 8'h00, 8'h00, 8'h00, 4'b0000});
    repeat (2) @(negedge clk);
    reset = 0;
    ticks(15); idle();
    chk("after_reset", {clock_minute, clock_second}, 16'h0001);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcf77_sync_clock.md
# dcf77_sync_clock

Parametrised successor of the DCF77-synchronised free-running clock: keeps BCD date/time running from a clock-enable tick and stays correct through leap years and leap seconds. It also qualifies incoming DCF77 frames against its own running time before accepting them, so one corrupted frame cannot overwrite good time. It sits between the DCF77 decoder and the display/output logic, driving an `if_date_time` interface plus lock-status flags.

## Interface
- `TICKS_PER_SEC`, 100: `clk_en` pulses per second; counter width `$clog2(TICKS_PER_SEC)`.
- `SYNC_PHASE`, 7: value loaded into the tick counter on an accepted sync. Must be < `TICKS_PER_SEC`.
- `CONFIRM`, 2: number of consecutive consistent frames needed to reach LOCKED; range 1..15.
- `REJECT_MAX`, 3: number of consecutive inconsistent frames in LOCKED that force re-acquisition; range 1..15.
- `HOLDOVER_SEC`, 3600: seconds without an accepted frame before LOCKED drops to HOLDOVER.
- `Y00_LEAP`, 1: 1 = year 00 is a leap year (the year 2000).
- `reset  in  1`: reset. **Asynchronous, active-high.**
- `clk  in  1`: the block's only clock.
- `clk_en  in  1`: tick enable, `TICKS_PER_SEC` per second. All state advances only on `clk_en`.
- `dcf77_sync  in  1`: decoded-frame-valid pulse, aligned to the minute marker. Qualified by `clk_en`.
- `leap_announce  in  1`: DCF77 leap-second announcement bit. Sampled together with `dcf77_sync`.
- `dcf77  if_date_time  -`: received date/time (input modport).
- `clock  if_date_time  -`: running date/time (output); combinational from the registers.
- `locked  out  1`: state is LOCKED.
- `holdover  out  1`: state is HOLDOVER.
- `reject  out  1`: one-cycle pulse on a `clk_en` cycle where a frame was refused.
- `sec_pulse  out  1`: one-cycle pulse on each `clk_en` where `second` advances.

## Operation
- **Reset values:**
  - date/time fields: year 00, month 01, day 01, day_of_week 1, 00:00:00.
  - internal: counter 0, state FREE, confirm and reject counts 0, holdover timer 0, leap_pending 0.
  - outputs: all status outputs 0.
- **Consistent frame:** local second == 00 and the dcf77 fields (minute, hour, day, month, year, day_of_week) equal the local fields. Because the counter is re-phased every minute, the local second rolls to 00 about `SYNC_PHASE` ticks before the next marker.
- **Load action:** copy dcf77 date/time, set second=00 and counter=`SYNC_PHASE`, clear holdover timer, latch leap_pending |= leap_announce.
- **State machine (evaluated on a `clk_en` with `dcf77_sync`):**
  - FREE: any frame → load; confirm=1; go to ACQUIRE, or straight to LOCKED if `CONFIRM`==1.
  - ACQUIRE / HOLDOVER, consistent frame: load; confirm+1; at `CONFIRM`, go to LOCKED and clear reject count.
  - ACQUIRE / HOLDOVER, inconsistent frame: load; confirm=1; go to ACQUIRE; pulse `reject`.
  - LOCKED, consistent frame: load; reject count=0.
  - LOCKED, inconsistent frame: no load; pulse `reject`; reject count+1. At `REJECT_MAX`: load; confirm=1; go to ACQUIRE.
- **Holdover timer:** increments on each `sec_pulse` and saturates. At `HOLDOVER_SEC` in LOCKED, go to HOLDOVER. Time keeps running in every state.
- **Counting:**
  - counter wraps at `TICKS_PER_SEC`-1; the wrap advances the second.
  - BCD carry chain: second → minute → hour → day/day_of_week (7→1) → month → year (99→00).
  - Month lengths: 30 days for 04, 06, 09, 11; February 28 or 29.
  - Leap year: year mod 4 == 0, except year 00, which is leap only if `Y00_LEAP`.
- **Leap second:** when leap_pending and the local time is minute 59, second 59 at the wrap, second becomes 60 with no carry. The next wrap goes 60→00 and carries into minute/hour etc. leap_pending clears at that point.
- **Simultaneous events:**
  - Sync processing on a `clk_en` replaces the tick when a load occurs.
  - A rejected frame lets the normal tick proceed on the same `clk_en`.
  - `sec_pulse` is not asserted on a load cycle.

## Timing
- Registered outputs update on the `clk` edge of the qualifying `clk_en` cycle; `clock` fields are valid the following cycle.
- `reject` and `sec_pulse` are high for exactly one `clk` cycle.
- Reset asserted mid-operation clears all state immediately, without waiting for `clk`. Counting resumes on the first `clk_en` after reset deasserts.

## Test plan
- **Reset then free run:** reset, then 6000 `clk_en` → clock reads 00:01:00, day 01, `locked`=0, 60 `sec_pulse`.
- **Acquisition:** frame 2024-02-28 23:59 dow 3, then a consistent frame 60 s later (2024-02-29 00:00, dow 4) → `locked`=1. Running 24 h more → 2024-02-29 advances to 03-01, dow 5. With year 23, 02-28 is followed by 03-01.
- **Bad frame rejection:** LOCKED at 12:00, one frame claiming 17:45 → `reject` pulse, clock unchanged, `locked` stays 1. Three consecutive bad frames → load 17:45, state ACQUIRE.
- **Leap second:** LOCKED at 00:58 with `leap_announce`=1 → seconds count 00:59:59, 00:59:60, 01:00:00; a second announce-free hour has no second 60.
- **Holdover and rollover:** `HOLDOVER_SEC`=10, LOCKED, no frames → `holdover`=1 after 10 s. Time 99-12-31 23:59:59 rolls to 00-01-01 00:00:00 with dow 7→1.
- **Async reset:** reset asserted mid-second with no `clk` edge → all outputs at reset values immediately.
